// File: rtl/rsnn_pkg.sv
// rsnn_pkg -- shared sizing constants and FSM state type for the recurrent
// spiking (leaky integrate-and-fire) network engine.
package rsnn_pkg;

  localparam int N_NEURON = 8;   // neurons updated per timestep
  localparam int N_SRC    = 16;  // 8 external + 8 recurrent sources per neuron
  localparam int V_W      = 8;   // membrane potential width (signed)
  localparam int W_W      = 8;   // synaptic weight width (signed)
  localparam int ACC_W    = 12;  // accumulator width: 16 x 8-bit never overflows
  localparam int SUM_W    = 13;  // leak + integrate intermediate width

  localparam logic signed [SUM_W-1:0] V_MAX = 13'sd127;
  localparam logic signed [SUM_W-1:0] V_MIN = -13'sd128;

  // ACC cycle counter value that marks the last (accumulate-only) ACC cycle.
  localparam logic [4:0] ACC_LAST = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rsnn_lif_update.sv
// rsnn_lif_update -- combinational leak / integrate / saturate / threshold
// for one neuron.
//   v           : current membrane potential (signed)
//   acc         : weighted spike sum for this timestep (signed)
//   decay_shift : leak shift; leak term is v >>> decay_shift (0 = full leak)
//   threshold   : unsigned firing threshold
//   v_next      : membrane value to store (0 after firing)
//   fire        : spike bit for this neuron
module rsnn_lif_update
  import rsnn_pkg::*;
(
  input  logic signed [V_W-1:0]   v,
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [2:0]       decay_shift,
  input  logic        [6:0]       threshold,
  output logic signed [V_W-1:0]   v_next,
  output logic                    fire
);

  logic signed [SUM_W-1:0] v_ext;
  logic signed [SUM_W-1:0] leak;
  logic signed [SUM_W-1:0] sum;
  logic signed [V_W-1:0]   v_sat;

  // NOTE: every always_comb output gets a default at the top so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    v_ext  = {{(SUM_W-V_W){v[V_W-1]}}, v};
    leak   = v_ext >>> decay_shift;
    sum    = v_ext - leak + {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
    v_sat  = sum[V_W-1:0];
    if (sum > V_MAX)      v_sat = V_MAX[V_W-1:0];
    else if (sum < V_MIN) v_sat = V_MIN[V_W-1:0];
    // Threshold is unsigned; widen with a zero sign bit before the signed compare.
    fire   = (v_sat >= $signed({2'b00, threshold}));
    v_next = fire ? '0 : v_sat;
  end

endmodule

// File: rtl/rsnn_lif_engine.sv
// rsnn_lif_engine -- sequential 8-neuron recurrent LIF network engine.
// One start runs a full timestep: for each neuron, 16 weights are read from
// an external synchronous memory (17 ACC cycles), then one UPDATE cycle
// applies leak/integrate/threshold. A final DONE cycle publishes spikes.
// Busy time is 8 x 18 + 1 = 145 cycles.
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a timestep (accepted only when idle)
//   spikes_in         : external spikes, latched on acceptance
//   threshold         : firing threshold, latched on acceptance
//   decay_shift       : leak shift, latched on acceptance
//   w_addr, w_rd_en   : weight read request {neuron, src}; addr holds when idle
//   w_data            : signed weight, returned one cycle after w_rd_en
//   spikes_out        : spikes of the last completed timestep
//   busy, done        : not-idle flag, one-cycle completion pulse
// Build option: define RSNN_REFRACTORY_EN so a neuron that fired in the
// previous timestep skips integration for one timestep.
module rsnn_lif_engine
  import rsnn_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [7:0]     spikes_in,
  input  logic [6:0]     threshold,
  input  logic [2:0]     decay_shift,
  output logic [6:0]     w_addr,
  output logic           w_rd_en,
  input  logic [W_W-1:0] w_data,
  output logic [7:0]     spikes_out,
  output logic           busy,
  output logic           done
);

  state_t state_q, state_d;

  logic [2:0]              neuron_q;
  logic [4:0]              cnt_q;       // ACC cycle index 0..16
  logic [7:0]              spikes_in_q;
  logic [6:0]              threshold_q;
  logic [2:0]              decay_shift_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [7:0]              shadow_q;
  logic [6:0]              w_addr_q;
  logic signed [V_W-1:0]   v_mem [N_NEURON];

  logic                    rd_en;
  logic [3:0]              src_idx;
  logic [N_SRC-1:0]        src_vec;
  logic signed [V_W-1:0]   v_next;
  logic                    fire;

  // Weight returned this cycle belongs to the source requested last cycle.
  // At cnt_q = 16 the 4-bit wrap gives source 15.
  assign src_idx = cnt_q[3:0] - 4'd1;
  // Recurrent sources read spikes_out, which only changes in DONE, so every
  // neuron sees the previous timestep's spikes.
  assign src_vec = {spikes_out, spikes_in_q};

  assign rd_en   = (state_q == ST_ACC) && !cnt_q[4];
  assign w_rd_en = rd_en;
  assign w_addr  = rd_en ? {neuron_q, cnt_q[3:0]} : w_addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  rsnn_lif_update u_update (
    .v           (v_mem[neuron_q]),
    .acc         (acc_q),
    .decay_shift (decay_shift_q),
    .threshold   (threshold_q),
    .v_next      (v_next),
    .fire        (fire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACC;
      ST_ACC:    if (cnt_q == ACC_LAST) state_d = ST_UPDATE;
      ST_UPDATE: state_d = (neuron_q == 3'(N_NEURON - 1)) ? ST_DONE : ST_ACC;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      neuron_q      <= '0;
      cnt_q         <= '0;
      spikes_in_q   <= '0;
      threshold_q   <= '0;
      decay_shift_q <= '0;
      acc_q         <= '0;
      shadow_q      <= '0;
      spikes_out    <= '0;
      w_addr_q      <= '0;
      // NOTE: the membrane array is network state that must start from rest,
      // so it is cleared by reset like any other register rather than left
      // as an uninitialised memory.
      for (int i = 0; i < N_NEURON; i++) v_mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            spikes_in_q   <= spikes_in;
            threshold_q   <= threshold;
            decay_shift_q <= decay_shift;
            neuron_q      <= '0;
            cnt_q         <= '0;
          end
        end
        ST_ACC: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd0)
            acc_q <= '0;
          else if (src_vec[src_idx])
            acc_q <= acc_q + {{(ACC_W-W_W){w_data[W_W-1]}}, w_data};
        end
        ST_UPDATE: begin
`ifdef RSNN_REFRACTORY_EN
          if (spikes_out[neuron_q]) begin
            v_mem[neuron_q]    <= '0;
            shadow_q[neuron_q] <= 1'b0;
          end else begin
            v_mem[neuron_q]    <= v_next;
            shadow_q[neuron_q] <= fire;
          end
`else
          v_mem[neuron_q]    <= v_next;
          shadow_q[neuron_q] <= fire;
`endif
          neuron_q <= neuron_q + 3'd1;
          cnt_q    <= '0;
        end
        ST_DONE: spikes_out <= shadow_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rsnn_lif_engine.md
RSNN_LIF_ENGINE -- requirements
Module: rsnn_lif_engine

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request one network timestep; accepted only in IDLE.
REQ-004 SHALL have port spikes_in, input, 8, external input spikes; sampled on the accepting edge.
REQ-005 SHALL have port threshold, input, 7, unsigned firing threshold (1..127); sampled on the accepting edge.
REQ-006 SHALL have port decay_shift, input, 3, leak shift amount; sampled on the accepting edge.
REQ-007 SHALL have port w_addr, output, 7, weight address {neuron[2:0], src[3:0]}.
REQ-008 SHALL have port w_rd_en, output, 1, weight read strobe.
REQ-009 SHALL have port w_data, input, 8, signed weight, valid exactly one cycle after w_rd_en.
REQ-010 SHALL have port spikes_out, output, 8, registered output spikes of last completed timestep.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at timestep completion.

Function
REQ-013 SHALL implement FSM IDLE -> ACC -> UPDATE -> (ACC for next neuron | DONE) -> IDLE.
REQ-014 SHALL process neurons 0..7 sequentially; per neuron, sources 0..7 = latched spikes_in, 8..15 = spikes_out of previous timestep.
REQ-015 ACC SHALL last 17 cycles: w_rd_en high with src 0..15 in cycles 1..16, w_data accumulated in cycles 2..17 only when the source spike is 1.
REQ-016 Accumulator SHALL be 12-bit signed, cleared at each neuron's first ACC cycle; no overflow possible.
REQ-017 UPDATE (1 cycle) SHALL compute v_new = v - (v >>> decay_shift) + acc in 13-bit signed, saturated to [-128, 127].
REQ-018 If v_new >= threshold: neuron spike bit = 1, stored membrane = 0; else spike bit = 0, stored membrane = v_new.
REQ-019 Membrane state SHALL be an internal 8 x 8-bit signed register array persisting across timesteps.
REQ-020 New spike bits SHALL be collected in a shadow register; spikes_out SHALL update only in DONE, so recurrent sources see previous-timestep spikes throughout.
REQ-021 DONE SHALL last exactly 1 cycle with done = 1; total busy time SHALL be 145 cycles (8 x 18 + 1).
REQ-022 start asserted while busy SHALL be ignored; start held high in IDLE after DONE SHALL begin a new timestep on the next edge.
REQ-023 w_rd_en SHALL be 0 outside ACC cycles 1..16; w_addr SHALL hold its last value when w_rd_en = 0.
REQ-024 decay_shift = 0 SHALL yield full leak (v - v = 0 before adding acc).

Reset
REQ-025 reset SHALL return FSM to IDLE and zero busy, done, w_rd_en, w_addr, spikes_out, shadow spikes, accumulator and all membranes.
REQ-026 reset mid-timestep SHALL abort without asserting done; reset has priority over start.

Configuration
REQ-027 With RSNN_REFRACTORY_EN defined, a neuron whose spikes_out bit is 1 SHALL skip integration in UPDATE: membrane stays 0, spike bit = 0; w_rd_en sequence unchanged.
REQ-028 Without RSNN_REFRACTORY_EN, every neuron SHALL integrate every timestep per REQ-017/018.

Structure
REQ-029 Package rsnn_pkg SHALL hold N_NEURON=8, N_SRC=16, V_W=8, W_W=8, ACC_W=12, and the FSM state enum.
REQ-030 Leak/saturate/threshold logic SHALL be a combinational sub-module rsnn_lif_update.

Verification
REQ-031 Reset, then start with spikes_in=0, all weights 0 -> done at cycle 145, spikes_out=0x00, membranes 0.
REQ-032 spikes_in=0x01, w[n][0]=+50 for all n, threshold=40, decay_shift=1 -> spikes_out=0xFF, membranes 0.
REQ-033 spikes_in=0xFF, all weights +127, threshold=127 -> acc=1016 saturates v to 127, spikes_out=0xFF.
REQ-034 Step 1 spikes_in=0x01 firing neuron 0; step 2 spikes_in=0x00, w[1][8]=+60, threshold=50 -> neuron 1 fires via recurrence (0x02 without RSNN_REFRACTORY_EN).
REQ-035 With RSNN_REFRACTORY_EN, repeat REQ-032 twice -> step 2 spikes_out=0x00, step 3 0xFF.
REQ-036 Assert reset at busy cycle 70 -> done never pulses, spikes_out=0x00; start pulses during busy produce no extra timestep.
